// File: rtl/multicycle_control.sv
// Multicycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencer for a 32-bit
// load/store ISA, driving PC, register-file indices, ALU selects and memory strobes.
module multicycle_control #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          IMM_W    = 14
) (
   input  logic        clock,
   input  logic        reset,
   output logic        imem_req,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc,
   output logic [3:0]  Rs1,
   output logic [3:0]  Rs2,
   output logic [3:0]  Rd,
   output logic        RegWRd,
   output logic        RegWRs,
   output logic [1:0]  alu_op,
   output logic        alu_src_imm,
   output logic [31:0] imm_ext,
   input  logic        alu_zero,
   output logic        mem_rd,
   output logic        mem_wr,
   input  logic        mem_ready,
   output logic        wb_sel,
   output logic        illegal
);

   localparam logic [5:0] OP_AND   = 6'd0;
   localparam logic [5:0] OP_ADD   = 6'd1;
   localparam logic [5:0] OP_SUB   = 6'd2;
   localparam logic [5:0] OP_ANDI  = 6'd3;
   localparam logic [5:0] OP_ADDI  = 6'd4;
   localparam logic [5:0] OP_LW    = 6'd5;
   localparam logic [5:0] OP_LWPOI = 6'd6;
   localparam logic [5:0] OP_SW    = 6'd7;
   localparam logic [5:0] OP_BEQ   = 6'd8;
   localparam logic [5:0] OP_J     = 6'd9;

   localparam logic [1:0] ALU_AND = 2'd0;
   localparam logic [1:0] ALU_ADD = 2'd1;
   localparam logic [1:0] ALU_SUB = 2'd2;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_WB
   } state_t;

   state_t      state_reg;
   logic [31:0] pc_reg;
   logic [31:0] ir_reg;
   logic        reg_wrd_reg;
   logic        reg_wrs_reg;
   logic        mem_rd_reg;
   logic        mem_wr_reg;
   logic        illegal_reg;
   logic [1:0]  alu_op_reg;
   logic        alu_src_imm_reg;
   logic        wb_sel_reg;

   logic [5:0]  opcode;
   logic        is_load;

   function automatic logic op_defined(input logic [5:0] op);
      return op <= OP_J;
   endfunction

   function automatic logic [1:0] alu_op_of(input logic [5:0] op);
      case (op)
         OP_AND, OP_ANDI: return ALU_AND;
         OP_SUB, OP_BEQ:  return ALU_SUB;
         default:         return ALU_ADD;
      endcase
   endfunction

   function automatic logic src_imm_of(input logic [5:0] op);
      case (op)
         OP_ANDI, OP_ADDI, OP_LW, OP_LWPOI, OP_SW: return 1'b1;
         default:                                 return 1'b0;
      endcase
   endfunction

   assign opcode  = ir_reg[31:26];
   assign is_load = (opcode == OP_LW) || (opcode == OP_LWPOI);

   // Fields come straight off the instruction register, so they stay put until the next fetch.
   assign Rd      = ir_reg[25:22];
   assign Rs1     = ir_reg[21:18];
   assign Rs2     = ((opcode == OP_SW) || (opcode == OP_BEQ)) ? ir_reg[25:22] : ir_reg[17:14];
   assign imm_ext = {{(32-IMM_W){ir_reg[IMM_W-1]}}, ir_reg[IMM_W-1:0]};

   // Decoding the state register lets the very first post-reset cycle issue a fetch.
   assign imem_req    = (state_reg == ST_FETCH);
   assign pc          = pc_reg;
   assign RegWRd      = reg_wrd_reg;
   assign RegWRs      = reg_wrs_reg;
   assign mem_rd      = mem_rd_reg;
   assign mem_wr      = mem_wr_reg;
   assign illegal     = illegal_reg;
   assign alu_op      = alu_op_reg;
   assign alu_src_imm = alu_src_imm_reg;
   assign wb_sel      = wb_sel_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg       <= ST_FETCH;
         pc_reg          <= RESET_PC;
         ir_reg          <= '0;
         reg_wrd_reg     <= 1'b0;
         reg_wrs_reg     <= 1'b0;
         mem_rd_reg      <= 1'b0;
         mem_wr_reg      <= 1'b0;
         illegal_reg     <= 1'b0;
         alu_op_reg      <= ALU_AND;
         alu_src_imm_reg <= 1'b0;
         wb_sel_reg      <= 1'b0;
      end else begin
         reg_wrd_reg <= 1'b0;
         reg_wrs_reg <= 1'b0;
         illegal_reg <= 1'b0;
         case (state_reg)
            ST_FETCH: begin
               if (imem_ready) begin
                  ir_reg      <= imem_rdata;
                  pc_reg      <= pc_reg + 32'd1;
                  illegal_reg <= !op_defined(imem_rdata[31:26]);
                  state_reg   <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               if (opcode == OP_J) begin
                  pc_reg    <= pc_reg + imm_ext;
                  state_reg <= ST_FETCH;
               end else if (!op_defined(opcode)) begin
                  state_reg <= ST_FETCH;
               end else begin
                  // ALU selects persist past EXEC so the address/result stays valid in MEM and WB.
                  alu_op_reg      <= alu_op_of(opcode);
                  alu_src_imm_reg <= src_imm_of(opcode);
                  state_reg       <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (opcode == OP_BEQ) begin
                  if (alu_zero) begin
                     pc_reg <= pc_reg + imm_ext;
                  end
                  state_reg <= ST_FETCH;
               end else if (is_load) begin
                  mem_rd_reg <= 1'b1;
                  state_reg  <= ST_MEM;
               end else if (opcode == OP_SW) begin
                  mem_wr_reg <= 1'b1;
                  state_reg  <= ST_MEM;
               end else begin
                  reg_wrd_reg <= 1'b1;
                  wb_sel_reg  <= 1'b0;
                  state_reg   <= ST_WB;
               end
            end
            ST_MEM: begin
               if (mem_ready) begin
                  mem_rd_reg <= 1'b0;
                  mem_wr_reg <= 1'b0;
                  if (opcode == OP_SW) begin
                     state_reg <= ST_FETCH;
                  end else begin
                     reg_wrd_reg <= 1'b1;
                     reg_wrs_reg <= (opcode == OP_LWPOI);
                     wb_sel_reg  <= 1'b1;
                     state_reg   <= ST_WB;
                  end
               end
            end
            ST_WB: begin
               state_reg <= ST_FETCH;
            end
            default: begin
               state_reg <= ST_FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: an instruction-level model expands each instruction
// into its expected per-cycle outputs; a single compare process checks them every cycle.
module tb_multicycle_control;

   logic        clock = 1'b0;
   logic        reset;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        alu_zero;
   logic        mem_ready;

   logic        imem_req, RegWRd, RegWRs, alu_src_imm, mem_rd, mem_wr, wb_sel, illegal;
   logic [31:0] pc, imm_ext;
   logic [3:0]  Rs1, Rs2, Rd;
   logic [1:0]  alu_op;

   logic        w_imem_req, w_RegWRd, w_RegWRs, w_alu_src_imm, w_mem_rd, w_mem_wr, w_wb_sel, w_illegal;
   logic [31:0] w_pc, w_imm_ext;
   logic [3:0]  w_Rs1, w_Rs2, w_Rd;
   logic [1:0]  w_alu_op;

   always #5 clock = ~clock;

   multicycle_control #(.RESET_PC(32'h0000_0000), .IMM_W(14)) dut (
      .clock(clock), .reset(reset),
      .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .pc(pc), .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd),
      .RegWRd(RegWRd), .RegWRs(RegWRs), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
      .imm_ext(imm_ext), .alu_zero(alu_zero), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_ready(mem_ready), .wb_sel(wb_sel), .illegal(illegal)
   );

   // Second instance only exercises PC wrap from the top of the address space.
   multicycle_control #(.RESET_PC(32'hFFFF_FFFF), .IMM_W(14)) u_wrap (
      .clock(clock), .reset(reset),
      .imem_req(w_imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .pc(w_pc), .Rs1(w_Rs1), .Rs2(w_Rs2), .Rd(w_Rd),
      .RegWRd(w_RegWRd), .RegWRs(w_RegWRs), .alu_op(w_alu_op), .alu_src_imm(w_alu_src_imm),
      .imm_ext(w_imm_ext), .alu_zero(alu_zero), .mem_rd(w_mem_rd), .mem_wr(w_mem_wr),
      .mem_ready(mem_ready), .wb_sel(w_wb_sel), .illegal(w_illegal)
   );

   typedef struct {
      bit          valid;
      bit          imem_req, mem_rd, mem_wr, regwrd, regwrs, illegal;
      logic [31:0] pc;
      bit          chk_fields;
      logic [3:0]  rs1, rs2, rd;
      logic [31:0] imm;
      bit          chk_alu;
      logic [1:0]  alu_op;
      bit          src;
      bit          chk_wb;
      bit          wb_sel;
      bit          chk_rst;
   } exp_t;

   exp_t        ex;
   int          total = 0;
   int          passed = 0;
   logic [31:0] mpc;
   int          cyc_idx, rst_at, cycles;
   bit          aborted, post_rst;
   int          memrd_cnt, illegal_cnt;
   logic [31:0] first_pc;
   logic        first_memwr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act === expv) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
   endtask

   always @(negedge clock) begin
      if (ex.valid) begin
         check("imem_req", 32'(imem_req), 32'(ex.imem_req));
         check("mem_rd",   32'(mem_rd),   32'(ex.mem_rd));
         check("mem_wr",   32'(mem_wr),   32'(ex.mem_wr));
         check("RegWRd",   32'(RegWRd),   32'(ex.regwrd));
         check("RegWRs",   32'(RegWRs),   32'(ex.regwrs));
         check("illegal",  32'(illegal),  32'(ex.illegal));
         check("pc",       pc,            ex.pc);
         if (ex.chk_fields) begin
            check("Rs1",     32'(Rs1), 32'(ex.rs1));
            check("Rs2",     32'(Rs2), 32'(ex.rs2));
            check("Rd",      32'(Rd),  32'(ex.rd));
            check("imm_ext", imm_ext,  ex.imm);
         end
         if (ex.chk_alu) begin
            check("alu_op",      32'(alu_op),      32'(ex.alu_op));
            check("alu_src_imm", 32'(alu_src_imm), 32'(ex.src));
         end
         if (ex.chk_wb) check("wb_sel", 32'(wb_sel), 32'(ex.wb_sel));
         if (ex.chk_rst) begin
            check("rst_alu_op", 32'(alu_op),      32'd0);
            check("rst_src",    32'(alu_src_imm), 32'd0);
            check("rst_wb_sel", 32'(wb_sel),      32'd0);
         end
      end
   end

   function automatic exp_t base();
      exp_t e;
      e = '{default: 0};
      e.pc = mpc;
      return e;
   endfunction

   function automatic logic [31:0] sext14(input logic [13:0] i);
      return {{18{i[13]}}, i};
   endfunction

   task automatic step(input exp_t e, input bit iready, input logic [31:0] irdata,
                       input bit mready, input bit z);
      @(posedge clock); #1;
      reset      = (cyc_idx == rst_at);
      imem_ready = iready;
      imem_rdata = irdata;
      mem_ready  = mready;
      alu_zero   = z;
      ex         = e;
      ex.valid   = 1'b1;
      ex.chk_rst = post_rst;
      post_rst   = 1'b0;
      @(negedge clock);
      if (cyc_idx == 0) begin
         first_pc    = pc;
         first_memwr = mem_wr;
      end
      memrd_cnt   += int'(mem_rd);
      illegal_cnt += int'(illegal);
      if (reset) begin
         aborted  = 1'b1;
         post_rst = 1'b1;
         mpc      = 32'h0000_0000;
      end
      cyc_idx++;
   endtask

   // Expands one instruction into the per-cycle outputs required by its semantics.
   task automatic run_instr(input logic [31:0] instr, input int fw, input int mw,
                            input bit z, input int rst_i);
      logic [5:0]  op;
      logic [31:0] imm;
      bit          load, sw, defd;
      exp_t        f, e;
      op   = instr[31:26];
      imm  = sext14(instr[13:0]);
      load = (op == 6'd5) || (op == 6'd6);
      sw   = (op == 6'd7);
      defd = (op <= 6'd9);
      cyc_idx = 0; rst_at = rst_i; aborted = 0; memrd_cnt = 0; illegal_cnt = 0;
      for (int k = 0; k <= fw; k++) begin
         e = base();
         e.imem_req = 1'b1;
         step(e, k == fw, (k == fw) ? instr : $urandom, 1'($urandom), 1'($urandom));
         if (aborted) begin cycles = cyc_idx; return; end
      end
      mpc = mpc + 32'd1;
      f = base();
      f.chk_fields = 1'b1;
      f.rd  = instr[25:22];
      f.rs1 = instr[21:18];
      f.rs2 = (op == 6'd7 || op == 6'd8) ? instr[25:22] : instr[17:14];
      f.imm = imm;
      e = f;
      e.illegal = !defd;
      step(e, 1'($urandom), $urandom, 1'($urandom), 1'($urandom));
      if (aborted || !defd) begin cycles = cyc_idx; return; end
      if (op == 6'd9) begin mpc = mpc + imm; cycles = cyc_idx; return; end
      e = f;
      e.chk_alu = 1'b1;
      e.alu_op  = (op == 6'd0 || op == 6'd3) ? 2'd0 : (op == 6'd2 || op == 6'd8) ? 2'd2 : 2'd1;
      e.src     = (op >= 6'd3 && op <= 6'd7);
      step(e, 1'($urandom), $urandom, 1'($urandom), z);
      if (aborted) begin cycles = cyc_idx; return; end
      if (op == 6'd8) begin
         if (z) mpc = mpc + imm;
         cycles = cyc_idx;
         return;
      end
      if (load || sw) begin
         for (int k = 0; k <= mw; k++) begin
            e = f;
            e.mem_rd = load;
            e.mem_wr = sw;
            step(e, 1'($urandom), $urandom, k == mw, 1'($urandom));
            if (aborted) begin cycles = cyc_idx; return; end
         end
         if (sw) begin cycles = cyc_idx; return; end
      end
      e = f;
      e.regwrd = 1'b1;
      e.regwrs = (op == 6'd6);
      e.chk_wb = 1'b1;
      e.wb_sel = load;
      step(e, 1'($urandom), $urandom, 1'($urandom), 1'($urandom));
      cycles = cyc_idx;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] instr;
      logic [5:0]  rop;
      int          rr;
      ex = '{default: 0};
      reset = 1'b1; imem_ready = 1'b0; imem_rdata = '0; alu_zero = 1'b0; mem_ready = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("reset_pc",     pc,             32'h0000_0000);
      check("reset_regwrd", 32'(RegWRd),    32'd0);
      check("reset_mem_rd", 32'(mem_rd),    32'd0);
      check("reset_wrap_pc", w_pc,          32'hFFFF_FFFF);
      mpc = 32'h0000_0000;
      post_rst = 1'b1;

      run_instr(32'h0489_0000, 0, 0, 1'b0, -1);
      check("add_latency", 32'(cycles),      32'd4);
      check("add_regwrd",  32'(RegWRd),      32'd1);
      check("add_rd",      32'(Rd),          32'd2);
      check("add_alu_op",  32'(alu_op),      32'd1);
      check("add_src",     32'(alu_src_imm), 32'd0);
      check("add_pc",      pc,               32'd1);
      check("wrap_pc",     w_pc,             32'd0);

      run_instr({6'd9, 12'd0, 14'd8}, 0, 0, 1'b0, -1);
      check("j_latency", 32'(cycles), 32'd2);

      run_instr({6'd8, 4'd3, 4'd3, 4'd0, 14'h3FFE}, 1, 0, 1'b1, -1);
      check("beq_fetch_pc", first_pc,      32'd10);
      check("beq_latency",  32'(cycles),   32'd4);

      run_instr({6'd6, 4'd3, 4'd5, 4'd0, 14'd2}, 0, 3, 1'b0, -1);
      check("beq_taken_pc",  first_pc,       32'd9);
      check("lwpoi_memrd",   32'(memrd_cnt), 32'd4);
      check("lwpoi_latency", 32'(cycles),    32'd8);
      check("lwpoi_regwrd",  32'(RegWRd),    32'd1);
      check("lwpoi_regwrs",  32'(RegWRs),    32'd1);
      check("lwpoi_wb_sel",  32'(wb_sel),    32'd1);
      check("lwpoi_rs1",     32'(Rs1),       32'd5);

      run_instr({6'd63, 26'h2AB_CDEF}, 0, 0, 1'b0, -1);
      check("illegal_pulses",  32'(illegal_cnt), 32'd1);
      check("illegal_latency", 32'(cycles),      32'd2);

      run_instr({6'd7, 4'd1, 4'd2, 4'd0, 14'd4}, 0, 5, 1'b0, 4);
      check("illegal_next_pc", first_pc, 32'd11);

      run_instr({6'd4, 4'd1, 4'd2, 4'd0, 14'h2000}, 0, 0, 1'b0, 3);
      check("sw_rst_pc",     first_pc,          32'd0);
      check("sw_rst_mem_wr", 32'(first_memwr),  32'd0);

      run_instr({6'd0, 4'd7, 4'd8, 4'd9, 14'd0}, 0, 0, 1'b0, -1);
      check("wb_rst_pc", first_pc, 32'd0);

      for (int n = 0; n < 300; n++) begin
         rr  = $urandom_range(15, 0);
         rop = (rr > 11) ? 6'($urandom_range(63, 10)) : 6'($urandom_range(9, 0));
         instr = {rop, 26'($urandom)};
         run_instr(instr, $urandom_range(2, 0), $urandom_range(3, 0), 1'($urandom),
                   ($urandom_range(19, 0) == 0) ? $urandom_range(6, 0) : -1);
      end

      @(posedge clock); #1;
      ex.valid = 1'b0;
      reset = 1'b0;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
